switch_reader: RTL and testbench

Input-side counterpart to the LED output path: samples the board's 16 slide switches on `clk100m`, synchronizes and debounces each bit independently, and exposes the stable switch vector. It also provides a valid/ready event stream that reports which bits rose or fell since the last accepted event. It sits between the board pins and any control logic that consumes user input.

---
 rtl/board_io_pkg.sv | 18 +
 rtl/debounce_bit.sv | 50 +++++
 rtl/switch_reader.sv | 95 +++++++++
 tb/tb_switch_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared board-level constants for the switch and LED paths.
// Debounce timing is derived from the system clock rate.
package board_io_pkg;

    localparam int CLK_HZ          = 100_000_000;
    localparam int NUM_SW          = 16;
    localparam int NUM_LED         = 16;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter and committed level.
// commit is high during the cycle whose closing edge updates state.
module debounce_bit
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic state,
    output logic commit
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          s_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        commit  = (s_q != state_q) && (cnt_q == CNT_MAX);
        state_d = state_q;
        cnt_d   = '0;
        if (commit) begin
            state_d = s_q;
        end else if (s_q != state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            s_q     <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= sw;
            s_q     <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/switch_reader.sv
// Debounced slide-switch vector plus a valid/ready stream of
// accumulated rise/fall changes since the last accepted event.
module switch_reader
    import board_io_pkg::*;
#(
    parameter int WIDTH           = NUM_SW,
    parameter int DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES
) (
    input  logic             clk100m,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_rise,
    output logic [WIDTH-1:0] evt_fall,
    output logic             evt_overflow
);

    logic [WIDTH-1:0] commit;
    logic [WIDTH-1:0] rise_c, fall_c;
    logic             any_c, accept;

    logic             st_q, st_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             ovf_q, ovf_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk100m),
            .rst_n (rst_n),
            .sw    (sw_in[i]),
            .state (sw_state[i]),
            .commit(commit[i])
        );
    end

    // Direction comes from the level before the commit edge.
    assign rise_c = commit & ~sw_state;
    assign fall_c = commit & sw_state;
    assign any_c  = |commit;
    assign accept = st_q && evt_ready;

    always_comb begin
        st_d   = st_q;
        rise_d = rise_q;
        fall_d = fall_q;
        ovf_d  = ovf_q;
        unique case (st_q)
            ST_IDLE: begin
                if (any_c) begin
                    st_d   = ST_PEND;
                    rise_d = rise_c;
                    fall_d = fall_c;
                    ovf_d  = 1'b0;
                end
            end
            ST_PEND: begin
                if (accept) begin
                    st_d   = any_c ? ST_PEND : ST_IDLE;
                    rise_d = rise_c;
                    fall_d = fall_c;
                    ovf_d  = 1'b0;
                end else begin
                    rise_d = rise_q | rise_c;
                    fall_d = fall_q | fall_c;
                    ovf_d  = ovf_q | (|((rise_q | fall_q) & commit));
                end
            end
        endcase
    end

    always_ff @(posedge clk100m) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            rise_q <= '0;
            fall_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            ovf_q  <= ovf_d;
        end
    end

    assign evt_valid    = st_q;
    assign evt_rise     = rise_q;
    assign evt_fall     = fall_q;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader with DEBOUNCE_CYCLES=4; accepted
// events are checked against a queue of hand-computed expectations.
module tb_switch_reader;

    typedef struct {
        logic [15:0] rise;
        logic [15:0] fall;
        logic [15:0] state;
        logic        ovf;
    } exp_t;

    logic        clk100m = 1'b0;
    logic        rst_n;
    logic [15:0] sw_in;
    logic [15:0] sw_state;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_rise;
    logic [15:0] evt_fall;
    logic        evt_overflow;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    switch_reader #(
        .WIDTH          (16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk100m     (clk100m),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .sw_state    (sw_state),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_rise    (evt_rise),
        .evt_fall    (evt_fall),
        .evt_overflow(evt_overflow)
    );

    always #5 clk100m = ~clk100m;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk100m);
        #1;
    endtask

    task automatic push(input logic [15:0] r, input logic [15:0] f,
                        input logic [15:0] s, input logic o);
        exp_t e;
        e.rise = r; e.fall = f; e.state = s; e.ovf = o;
        q.push_back(e);
    endtask

    // Monitor: every handshake must match the oldest expectation.
    always @(negedge clk100m) begin
        if (rst_n === 1'b1 && evt_valid && evt_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_evt", {16'h0, evt_rise}, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("evt_rise", {16'h0, evt_rise}, {16'h0, e.rise});
                chk("evt_fall", {16'h0, evt_fall}, {16'h0, e.fall});
                chk("evt_ovf", {31'h0, evt_overflow}, {31'h0, e.ovf});
                chk("evt_state", {16'h0, sw_state}, {16'h0, e.state});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        sw_in     = 16'h0000;
        evt_ready = 1'b1;
        tick(1);

        // Reset hold
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("rst_state", {16'h0, sw_state}, 32'h0);
            chk("rst_valid", {31'h0, evt_valid}, 32'h0);
        end
        rst_n = 1'b1;
        tick(3);
        chk("idle_valid", {31'h0, evt_valid}, 32'h0);

        // Single rise, latency 2 + DEBOUNCE_CYCLES
        sw_in = 16'h0001;
        push(16'h0001, 16'h0, 16'h0001, 1'b0);
        tick(5);
        chk("lat_early", {31'h0, evt_valid}, 32'h0);
        chk("lat_early_st", {16'h0, sw_state}, 32'h0);
        tick(1);
        chk("lat_valid", {31'h0, evt_valid}, 32'h1);
        chk("lat_state", {16'h0, sw_state}, 32'h1);
        chk("lat_rise", {16'h0, evt_rise}, 32'h1);
        tick(1);
        chk("lat_drop", {31'h0, evt_valid}, 32'h0);

        sw_in = 16'h0000;
        push(16'h0, 16'h0001, 16'h0000, 1'b0);
        tick(8);

        // Bouncing bit 3 never commits
        for (int k = 0; k < 5; k++) begin
            sw_in[3] = 1'b1;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                chk("bounce_valid", {31'h0, evt_valid}, 32'h0);
            end
            sw_in[3] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                chk("bounce_valid", {31'h0, evt_valid}, 32'h0);
            end
        end
        sw_in[3] = 1'b1;
        push(16'h0008, 16'h0, 16'h0008, 1'b0);
        tick(5);
        chk("bounce_early", {31'h0, evt_valid}, 32'h0);
        tick(1);
        chk("bounce_commit", {31'h0, evt_valid}, 32'h1);
        chk("bounce_state", {16'h0, sw_state}, 32'h8);
        tick(3);

        // Overflow with consumer stalled
        evt_ready = 1'b0;
        sw_in[0]  = 1'b1;
        tick(6);
        chk("ovf_first", {31'h0, evt_valid}, 32'h1);
        chk("ovf_first_ov", {31'h0, evt_overflow}, 32'h0);
        sw_in[0] = 1'b0;
        tick(6);
        chk("ovf_set", {31'h0, evt_overflow}, 32'h1);
        chk("ovf_rise", {16'h0, evt_rise}, 32'h1);
        chk("ovf_fall", {16'h0, evt_fall}, 32'h1);
        chk("ovf_state", {16'h0, sw_state}, 32'h8);
        push(16'h0001, 16'h0001, 16'h0008, 1'b1);
        evt_ready = 1'b1;
        tick(1);
        chk("acc_valid", {31'h0, evt_valid}, 32'h0);
        chk("acc_ovf", {31'h0, evt_overflow}, 32'h0);
        chk("acc_rise", {16'h0, evt_rise}, 32'h0);
        chk("acc_fall", {16'h0, evt_fall}, 32'h0);
        tick(3);

        // Commit of bit 5 on the accept edge of bit 2
        sw_in[2] = 1'b1;
        push(16'h0004, 16'h0, 16'h000c, 1'b0);
        push(16'h0020, 16'h0, 16'h002c, 1'b0);
        tick(1);
        sw_in[5] = 1'b1;
        tick(5);
        chk("bb_first", {16'h0, evt_rise}, 32'h4);
        tick(1);
        chk("bb_valid", {31'h0, evt_valid}, 32'h1);
        chk("bb_second", {16'h0, evt_rise}, 32'h20);
        chk("bb_ovf", {31'h0, evt_overflow}, 32'h0);
        tick(1);
        chk("bb_drop", {31'h0, evt_valid}, 32'h0);
        tick(3);

        // Reset mid-count with an event pending
        evt_ready = 1'b0;
        sw_in[7]  = 1'b1;
        tick(6);
        sw_in[9] = 1'b1;
        tick(4);
        chk("pre_rst_valid", {31'h0, evt_valid}, 32'h1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_state", {16'h0, sw_state}, 32'h0);
        chk("mid_rst_valid", {31'h0, evt_valid}, 32'h0);
        chk("mid_rst_rise", {16'h0, evt_rise}, 32'h0);
        chk("mid_rst_fall", {16'h0, evt_fall}, 32'h0);
        chk("mid_rst_ovf", {31'h0, evt_overflow}, 32'h0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        push(16'h02ac, 16'h0, 16'h02ac, 1'b0);
        tick(5);
        chk("rel_early", {31'h0, evt_valid}, 32'h0);
        tick(1);
        chk("rel_valid", {31'h0, evt_valid}, 32'h1);
        chk("rel_state", {16'h0, sw_state}, 32'h2ac);
        tick(4);

        chk("queue_empty", q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
